mem_port_arbiter: RTL and testbench

- Shares one single-ported memory bus between the instruction-fetch requester (fetch stage) and the data load/store requester (memory stage).
- Grants one requester at a time and drives the shared bus from registered copies of the granted request.
- Routes read data back to the granted requester and pulses that requester's done signal.
- Sits between the pipeline stages and the memory/cache interface.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/arb_grant_select.sv | 34 +++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and default widths for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int c_DEFAULT_ADDR_WIDTH = 32;
    localparam int c_DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/arb_grant_select.sv
// ============================================================================
// Module   : arb_grant_select
// Purpose  : Combinational winner selection between fetch and load/store.
//            MEM_ARB_ROUND_ROBIN_EN selects alternating priority on ties.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_grant_select
    import mem_arb_pkg::*;
(
    input  logic    instr_req,
    input  logic    data_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  req_id_t last_grant,
`endif
    output logic    grant_valid,
    output req_id_t grant_id
);

    always_comb begin
        grant_valid = instr_req | data_req;
        grant_id    = data_req ? REQ_DATA : REQ_INSTR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie the requester that did not win last time goes first
        if (instr_req && data_req) begin
            grant_id = (last_grant == REQ_DATA) ? REQ_INSTR : REQ_DATA;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory bus between fetch and load/store requesters.
//            Optional macro MEM_ARB_ROUND_ROBIN_EN enables round-robin ties.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   instr_addr,
    input  logic                    instr_req,
    output logic [DATA_WIDTH-1:0]   instr_rdata,
    output logic                    instr_done,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic                    data_req,
    input  logic                    data_we,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic [DATA_WIDTH/8-1:0] data_wstrb,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_done,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack
);

    arb_state_t              state_q,       state_d;
    req_id_t                 grant_q,       grant_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,    mem_addr_d;
    logic                    mem_req_q,     mem_req_d;
    logic                    mem_we_q,      mem_we_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q,   mem_wdata_d;
    logic [DATA_WIDTH/8-1:0] mem_wstrb_q,   mem_wstrb_d;
    logic [DATA_WIDTH-1:0]   instr_rdata_q, instr_rdata_d;
    logic [DATA_WIDTH-1:0]   data_rdata_q,  data_rdata_d;
    logic                    instr_done_q,  instr_done_d;
    logic                    data_done_q,   data_done_d;

    logic    w_grant_valid;
    req_id_t w_grant_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_grant_q, last_grant_d;
`endif

    arb_grant_select u_grant_select (
        .instr_req   (instr_req),
        .data_req    (data_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_q),
`endif
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= REQ_INSTR;
            mem_addr_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= '0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            instr_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q  <= REQ_DATA;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mem_addr_q    <= mem_addr_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
            instr_done_q  <= instr_done_d;
            data_done_q   <= data_done_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        mem_addr_d    = mem_addr_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        instr_done_d  = 1'b0;
        data_done_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_grant_valid) begin
                    state_d   = BUSY;
                    mem_req_d = 1'b1;
                    grant_d   = w_grant_id;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = w_grant_id;
`endif
                    if (w_grant_id == REQ_DATA) begin
                        mem_addr_d  = data_addr;
                        mem_we_d    = data_we;
                        mem_wdata_d = data_wdata;
                        mem_wstrb_d = data_we ? data_wstrb : '0;
                    end else begin
                        mem_addr_d  = instr_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    // Stores leave the requester's read register untouched
                    if (grant_q == REQ_DATA) begin
                        data_done_d = 1'b1;
                        if (!mem_we_q) data_rdata_d = mem_rdata;
                    end else begin
                        instr_done_d = 1'b1;
                        if (!mem_we_q) instr_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign mem_addr    = mem_addr_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign instr_rdata = instr_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign instr_done  = instr_done_q;
    assign data_done   = data_done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter; honours MEM_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam logic [31:0] c_GARBAGE = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_addr = '0;
    logic        instr_req  = 1'b0;
    logic [31:0] instr_rdata;
    logic        instr_done;
    logic [31:0] data_addr  = '0;
    logic        data_req   = 1'b0;
    logic        data_we    = 1'b0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_rdata;
    logic        data_done;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata  = c_GARBAGE;
    logic        mem_ack    = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        bit          seen;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          stable;
        int          req_cycles;
        int          lat;
        bit          req_after;
        bit          idone;
        bit          ddone;
        logic [31:0] irdata;
        logic [31:0] drdata;
    } obs_t;

    txn_t        sb[$];
    txn_t        e;
    obs_t        o;
    logic [31:0] m_irdata = '0;
    logic [31:0] m_drdata = '0;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .instr_addr  (instr_addr),
        .instr_req   (instr_req),
        .instr_rdata (instr_rdata),
        .instr_done  (instr_done),
        .data_addr   (data_addr),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_wdata  (data_wdata),
        .data_wstrb  (data_wstrb),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Bus responder: waits for mem_req, acks after ack_delay BUSY cycles, records what it saw
    task automatic run_bus(input int ack_delay, input logic [31:0] rd, output obs_t ob);
        ob.seen = 1'b0; ob.stable = 1'b1; ob.req_cycles = 0; ob.lat = 0;
        ob.req_after = 1'b0; ob.idone = 1'b0; ob.ddone = 1'b0;
        ob.addr = '0; ob.we = 1'b0; ob.wdata = '0; ob.wstrb = '0;
        ob.irdata = '0; ob.drdata = '0;
        for (int i = 0; i < 20 && !mem_req; i++) begin
            tick();
            ob.lat++;
        end
        if (!mem_req) return;
        ob.seen  = 1'b1;
        ob.addr  = mem_addr;
        ob.we    = mem_we;
        ob.wdata = mem_wdata;
        ob.wstrb = mem_wstrb;
        for (int i = 0; i <= ack_delay; i++) begin
            if (mem_req) ob.req_cycles++;
            if (mem_addr !== ob.addr || mem_we !== ob.we || mem_wdata !== ob.wdata ||
                mem_wstrb !== ob.wstrb) ob.stable = 1'b0;
            if (i == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end
            tick();
            ob.lat++;
        end
        mem_ack   = 1'b0;
        mem_rdata = c_GARBAGE;
        ob.req_after = mem_req;
        ob.idone     = instr_done;
        ob.ddone     = data_done;
        ob.irdata    = instr_rdata;
        ob.drdata    = data_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({mem_req, instr_done, data_done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: got req/idone/ddone=%b expected 000", {mem_req, instr_done, data_done});
        end
        n_cmp++;
        if ({mem_addr, mem_we, mem_wdata, mem_wstrb} !== '0) begin
            n_err++;
            $display("FAIL reset_bus: got addr=%h we=%b wdata=%h wstrb=%h expected all 0",
                     mem_addr, mem_we, mem_wdata, mem_wstrb);
        end
        n_cmp++;
        if (instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got i=%h d=%h expected 0/0", instr_rdata, data_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        sb.push_back('{1'b0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h0050_0093});
        instr_addr = 32'h100;
        instr_req  = 1'b1;
        run_bus(1, 32'h0050_0093, o);
        instr_req = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (!o.seen) begin
            n_err++;
            $display("FAIL fetch_timeout: mem_req not seen within 20 cycles");
            return;
        end
        n_cmp++;
        if (o.addr !== e.addr || o.we !== e.we || o.wstrb !== e.wstrb) begin
            n_err++;
            $display("FAIL fetch_bus: got addr=%h we=%b wstrb=%h expected %h %b %h",
                     o.addr, o.we, o.wstrb, e.addr, e.we, e.wstrb);
        end
        n_cmp++;
        if (o.req_cycles !== 2 || !o.stable || o.req_after) begin
            n_err++;
            $display("FAIL fetch_busy: got cycles=%0d stable=%b req_after=%b expected 2 1 0",
                     o.req_cycles, o.stable, o.req_after);
        end
        n_cmp++;
        if (o.idone !== 1'b1 || o.ddone !== 1'b0 || o.lat !== 3) begin
            n_err++;
            $display("FAIL fetch_done: got idone=%b ddone=%b lat=%0d expected 1 0 3", o.idone, o.ddone, o.lat);
        end
        m_irdata = e.rdata;
        n_cmp++;
        if (o.irdata !== m_irdata) begin
            n_err++;
            $display("FAIL fetch_rdata: got %h expected %h", o.irdata, m_irdata);
        end
        tick();
        n_cmp++;
        if (instr_done !== 1'b0 || data_done !== 1'b0 || mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_pulse: got idone=%b ddone=%b req=%b expected 0 0 0", instr_done, data_done, mem_req);
        end
    endtask

    task automatic test_store();
        sb.push_back('{1'b1, 32'h2004, 1'b1, 32'hDEAD_BEEF, 4'h3, 32'h1111_2222});
        data_addr  = 32'h2004;
        data_we    = 1'b1;
        data_wdata = 32'hDEAD_BEEF;
        data_wstrb = 4'h3;
        data_req   = 1'b1;
        run_bus(0, 32'h1111_2222, o);
        data_req = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (!o.seen || o.addr !== e.addr || o.we !== e.we || o.wdata !== e.wdata || o.wstrb !== e.wstrb) begin
            n_err++;
            $display("FAIL store_bus: got seen=%b addr=%h we=%b wdata=%h wstrb=%h expected 1 %h %b %h %h",
                     o.seen, o.addr, o.we, o.wdata, o.wstrb, e.addr, e.we, e.wdata, e.wstrb);
        end
        n_cmp++;
        if (o.ddone !== 1'b1 || o.idone !== 1'b0 || o.lat !== 2 || o.req_cycles !== 1) begin
            n_err++;
            $display("FAIL store_done: got ddone=%b idone=%b lat=%0d cycles=%0d expected 1 0 2 1",
                     o.ddone, o.idone, o.lat, o.req_cycles);
        end
        n_cmp++;
        if (o.drdata !== m_drdata || o.irdata !== m_irdata) begin
            n_err++;
            $display("FAIL store_rdata_hold: got d=%h i=%h expected %h %h", o.drdata, o.irdata, m_drdata, m_irdata);
        end
        tick();
    endtask

    task automatic test_load();
        sb.push_back('{1'b1, 32'h3008, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D});
        data_addr  = 32'h3008;
        data_we    = 1'b0;
        data_wstrb = 4'hF;
        data_req   = 1'b1;
        run_bus(2, 32'hCAFE_F00D, o);
        data_req = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (!o.seen || o.addr !== e.addr || o.we !== e.we || o.wstrb !== e.wstrb || o.req_cycles !== 3) begin
            n_err++;
            $display("FAIL load_bus: got seen=%b addr=%h we=%b wstrb=%h cycles=%0d expected 1 %h %b %h 3",
                     o.seen, o.addr, o.we, o.wstrb, o.req_cycles, e.addr, e.we, e.wstrb);
        end
        m_drdata = e.rdata;
        n_cmp++;
        if (o.ddone !== 1'b1 || o.drdata !== m_drdata || o.irdata !== m_irdata) begin
            n_err++;
            $display("FAIL load_rdata: got ddone=%b d=%h i=%h expected 1 %h %h", o.ddone, o.drdata, o.irdata,
                     m_drdata, m_irdata);
        end
        tick();
    endtask

    task automatic test_contention();
        bit exp_data[3];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_data = '{1'b0, 1'b1, 1'b0};
`else
        exp_data = '{1'b1, 1'b1, 1'b1};
`endif
        for (int k = 0; k < 3; k++)
            sb.push_back('{exp_data[k], exp_data[k] ? 32'h4000 : 32'h300, 1'b0, 32'h0, 4'h0, 32'h1000 + k});
        instr_addr = 32'h300;
        data_addr  = 32'h4000;
        data_we    = 1'b0;
        instr_req  = 1'b1;
        data_req   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_bus(0, 32'h1000 + k, o);
            e = sb.pop_front();
            n_cmp++;
            if (!o.seen || o.addr !== e.addr || o.ddone !== e.is_data || o.idone !== !e.is_data) begin
                n_err++;
                $display("FAIL contention_grant%0d: got seen=%b addr=%h ddone=%b idone=%b expected addr=%h data=%b",
                         k, o.seen, o.addr, o.ddone, o.idone, e.addr, e.is_data);
            end
            if (e.is_data) m_drdata = e.rdata;
            else           m_irdata = e.rdata;
            n_cmp++;
            if (o.drdata !== m_drdata || o.irdata !== m_irdata) begin
                n_err++;
                $display("FAIL contention_rdata%0d: got d=%h i=%h expected %h %h", k, o.drdata, o.irdata,
                         m_drdata, m_irdata);
            end
        end
        instr_req = 1'b0;
        data_req  = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        bit any;
        instr_addr = 32'h500;
        instr_req  = 1'b1;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            n_err++;
            $display("FAIL midrst_start: got req=%b addr=%h expected 1 00000500", mem_req, mem_addr);
        end
        tick();
        rst       = 1'b1;
        instr_req = 1'b0;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_req: got %b expected 0", mem_req);
        end
        m_irdata = '0;
        m_drdata = '0;
        any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            any |= instr_done | data_done | mem_req;
            tick();
        end
        n_cmp++;
        if (any !== 1'b0 || instr_rdata !== m_irdata || data_rdata !== m_drdata) begin
            n_err++;
            $display("FAIL midrst_quiet: got activity=%b i=%h d=%h expected 0 0 0", any, instr_rdata, data_rdata);
        end
        sb.push_back('{1'b0, 32'h600, 1'b0, 32'h0, 4'h0, 32'h0000_0777});
        instr_addr = 32'h600;
        instr_req  = 1'b1;
        run_bus(0, 32'h0000_0777, o);
        instr_req = 1'b0;
        e = sb.pop_front();
        m_irdata = e.rdata;
        n_cmp++;
        if (!o.seen || o.addr !== e.addr || o.idone !== 1'b1 || o.irdata !== m_irdata) begin
            n_err++;
            $display("FAIL midrst_fresh: got seen=%b addr=%h idone=%b i=%h expected 1 %h 1 %h",
                     o.seen, o.addr, o.idone, o.irdata, e.addr, m_irdata);
        end
        tick();
    endtask

    task automatic test_withdraw_stray();
        bit any;
        sb.push_back('{1'b0, 32'h700, 1'b0, 32'h0, 4'h0, 32'h0000_0888});
        instr_addr = 32'h700;
        instr_req  = 1'b1;
        tick();
        instr_req = 1'b0;
        run_bus(4, 32'h0000_0888, o);
        e = sb.pop_front();
        m_irdata = e.rdata;
        n_cmp++;
        if (!o.seen || o.idone !== 1'b1 || o.ddone !== 1'b0 || o.req_cycles !== 5 || o.irdata !== m_irdata) begin
            n_err++;
            $display("FAIL withdraw: got seen=%b idone=%b ddone=%b cycles=%0d i=%h expected 1 1 0 5 %h",
                     o.seen, o.idone, o.ddone, o.req_cycles, o.irdata, m_irdata);
        end
        tick();
        tick();
        n_cmp++;
        if (mem_req !== 1'b0 || instr_done !== 1'b0) begin
            n_err++;
            $display("FAIL withdraw_after: got req=%b idone=%b expected 0 0", mem_req, instr_done);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        any = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any |= mem_req | instr_done | data_done;
        end
        mem_ack   = 1'b0;
        mem_rdata = c_GARBAGE;
        tick();
        any |= mem_req | instr_done | data_done;
        n_cmp++;
        if (any !== 1'b0 || instr_rdata !== m_irdata || data_rdata !== m_drdata) begin
            n_err++;
            $display("FAIL stray_ack: got activity=%b i=%h d=%h expected 0 %h %h", any, instr_rdata, data_rdata,
                     m_irdata, m_drdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_load();
        test_contention();
        test_reset_mid_busy();
        test_withdraw_stray();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
